// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receive FSM state encoding and default widths.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int UART_COMP_W = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;
endpackage

// File: rtl/uart_receiver_if.sv
// Register-file side of the UART receiver: control inputs, holding register and flags.
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int COMP_W = UART_COMP_W
);
    logic                   rx_en;
    logic [COMP_W-1:0]      comp;
    logic                   rx_ack;
    logic                   err_clr;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   fr_err;
    logic                   ovr_err;
    logic                   busy;

    modport master (
        output rx_en, comp, rx_ack, err_clr,
        input  rx_data, rx_valid, fr_err, ovr_err, busy
    );

    modport slave (
        input  rx_en, comp, rx_ack, err_clr,
        output rx_data, rx_valid, fr_err, ovr_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high async line, plus a falling-edge detector.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rx_s = sync2_q;
    assign fall = ~sync2_q & prev_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine: start detect, mid-bit sampling, one-byte holding
// register with valid/ack handshake and sticky framing/overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int COMP_W = UART_COMP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_receiver_if.slave  bus
);
    logic rx_s, fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    rx_state_e              state_q, state_d;
    logic [COMP_W-1:0]      cnt_q, cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   fr_q, fr_d;
    logic                   ovr_q, ovr_d;
    logic                   stop_ok, stop_bad;
    logic [COMP_W-1:0]      comp_last, half_last;

    assign comp_last = bus.comp - COMP_W'(1);
    assign half_last = (bus.comp >> 1) - COMP_W'(1);

    // >= rather than == so a comp change mid-frame cannot strand the counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (bus.rx_en && fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q >= half_last) state_d = rx_s ? RX_IDLE : RX_DATA;
                else                    cnt_d   = cnt_q + COMP_W'(1);
            end
            RX_DATA: begin
                if (cnt_q >= comp_last) begin
                    shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + COMP_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q >= comp_last) begin
                    state_d  = RX_IDLE;
                    stop_ok  = rx_s;
                    stop_bad = ~rx_s;
                end else begin
                    cnt_d = cnt_q + COMP_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (!bus.rx_en) begin
            state_d  = RX_IDLE;
            stop_ok  = 1'b0;
            stop_bad = 1'b0;
        end
        if (state_d != state_q) begin
            cnt_d     = '0;
            bit_cnt_d = '0;
        end
    end

    // Error sets are applied after clears so a same-cycle event wins.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fr_d    = fr_q;
        ovr_d   = ovr_q;
        if (bus.rx_ack) valid_d = 1'b0;
        if (bus.err_clr) begin
            fr_d  = 1'b0;
            ovr_d = 1'b0;
        end
        if (stop_ok) begin
            if (!valid_q || bus.rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (stop_bad) fr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shift_q <= '0;
        else     shift_q <= shift_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fr_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fr_q    <= fr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;
    assign bus.fr_err   = fr_q;
    assign bus.ovr_err  = ovr_q;
    assign bus.busy     = (state_q != RX_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected bytes queued at send time, checked on delivery.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int COMPV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_receiver_if #(.COMP_W(16)) bus ();

    uart_receiver #(.COMP_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned t_start = 0;
    int unsigned pop_cyc = 0;
    int unsigned n_pop = 0;
    logic        auto_ack = 1'b1;
    logic        man_ack = 1'b0;
    logic [7:0]  sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops and acks each delivered byte while auto_ack is on.
    always @(negedge clk) begin
        if (auto_ack && bus.rx_valid && !bus.rx_ack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", {24'd0, bus.rx_data}, {24'd0, sb_q.pop_front()});
            end
            pop_cyc = cyc;
            n_pop++;
            bus.rx_ack = 1'b1;
        end else begin
            bus.rx_ack = man_ack;
        end
    end

    task automatic send(input logic [7:0] d, input logic stop);
        @(posedge clk); #1;
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = (i == 0) ? 1'b0 : (i == 9) ? stop : d[i-1];
            repeat (COMPV) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned t0, p0;

    initial begin
        bus.rx_en   = 1'b1;
        bus.comp    = 16'(COMPV);
        bus.rx_ack  = 1'b0;
        bus.err_clr = 1'b0;

        // reset state
        wait_n(3);
        chk("rst_data",  {24'd0, bus.rx_data}, 32'd0);
        chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_fr",    {31'd0, bus.fr_err}, 32'd0);
        chk("rst_ovr",   {31'd0, bus.ovr_err}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        wait_n(3);

        // basic byte with latency
        sb_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        t0 = t_start;
        wait_n(40);
        chk("latency", pop_cyc - t0, 32'd155);
        chk("basic_fr",  {31'd0, bus.fr_err}, 32'd0);
        chk("basic_ovr", {31'd0, bus.ovr_err}, 32'd0);
        chk("basic_sb",  sb_q.size(), 32'd0);

        // back-to-back with ack
        p0 = n_pop;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        wait_n(40);
        chk("b2b_pops", n_pop - p0, 32'd2);
        chk("b2b_ovr",  {31'd0, bus.ovr_err}, 32'd0);
        chk("b2b_sb",   sb_q.size(), 32'd0);

        // overrun
        auto_ack = 1'b0;
        sb_q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        wait_n(40);
        chk("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("ovr_data",  {24'd0, bus.rx_data}, {24'd0, sb_q.pop_front()});
        chk("ovr_flag",  {31'd0, bus.ovr_err}, 32'd1);
        man_ack = 1'b1;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        wait_n(3);
        chk("ack_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("clr_ovr",   {31'd0, bus.ovr_err}, 32'd0);
        chk("ack_hold",  {24'd0, bus.rx_data}, 32'h11);
        auto_ack = 1'b1;

        // framing error
        send(8'h3C, 1'b0);
        rx = 1'b1;
        wait_n(40);
        chk("fr_flag",  {31'd0, bus.fr_err}, 32'd1);
        chk("fr_valid", {31'd0, bus.rx_valid}, 32'd0);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        wait_n(2);
        chk("fr_clr", {31'd0, bus.fr_err}, 32'd0);

        // glitch rejection
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy", {31'd0, bus.busy}, 32'd1);
        wait_n(30);
        chk("glitch_idle",  {31'd0, bus.busy}, 32'd0);
        chk("glitch_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("glitch_fr",    {31'd0, bus.fr_err}, 32'd0);

        // abort via rx_en
        fork
            send(8'h5A, 1'b1);
            begin
                wait_n(60);
                chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
                bus.rx_en = 1'b0;
                @(negedge clk);
                chk("abort_busy", {31'd0, bus.busy}, 32'd0);
            end
        join
        bus.rx_en = 1'b1;
        wait_n(40);
        chk("abort_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("abort_fr",    {31'd0, bus.fr_err}, 32'd0);

        // asynchronous reset mid-frame with a held byte
        auto_ack = 1'b0;
        sb_q.push_back(8'h77);
        send(8'h77, 1'b1);
        wait_n(30);
        chk("pre_rst_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("pre_rst_data",  {24'd0, bus.rx_data}, {24'd0, sb_q.pop_front()});
        fork
            send(8'hC3, 1'b1);
            begin
                wait_n(50);
                chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
                #2 rst = 1'b1;
                #1;
                chk("arst_data",  {24'd0, bus.rx_data}, 32'd0);
                chk("arst_valid", {31'd0, bus.rx_valid}, 32'd0);
                chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        wait_n(20);
        chk("post_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("post_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
